// File: rtl/ras_pkg.sv
// ras_pkg: shared register numbers and the alias-table entry type for ras_unit.
package ras_pkg;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_SP   = 5'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] areg;
        logic       spill;
    } track_entry_t;
endpackage

// File: rtl/ras_track_table.sv
// ras_track_table: round-robin table of registers (or the spill slot) that hold a copy of ra.
module ras_track_table
    import ras_pkg::*;
#(
    parameter int TRACK_N = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [4:0] wr_reg,
    input  logic       wr_spill,
    input  logic       rd_wr_en,
    input  logic [4:0] rd_wr_reg,
    input  logic [4:0] query_reg,
    input  logic       query_load_dep,
    output logic       ra_hit
);
    localparam int RW = TRACK_N > 1 ? $clog2(TRACK_N) : 1;

    track_entry_t tbl [TRACK_N];
    logic [RW-1:0] rr, hit_idx, widx;
    logic          hit, alias_hit, spill_hit;
    logic [TRACK_N-1:0] kill;

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        alias_hit = 1'b0;
        spill_hit = 1'b0;
        kill      = '0;
        for (int i = 0; i < TRACK_N; i++) begin
            if (!hit && tbl[i].valid && (wr_spill ? tbl[i].spill : (!tbl[i].spill && tbl[i].areg == wr_reg))) begin
                hit     = 1'b1;
                hit_idx = RW'(i);
            end
            alias_hit |= tbl[i].valid && !tbl[i].spill && tbl[i].areg == query_reg;
            spill_hit |= tbl[i].valid && tbl[i].spill;
            kill[i]    = rd_wr_en && rd_wr_reg != REG_ZERO && tbl[i].valid && !tbl[i].spill && tbl[i].areg == rd_wr_reg;
        end
        widx   = hit ? hit_idx : rr;
        ra_hit = query_reg == REG_RA || alias_hit || (query_load_dep && spill_hit);
    end

    // The track write is applied after the rd kill so it wins on a same-register collision.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < TRACK_N; i++) tbl[i] <= '0;
            if (!rst_n) rr <= '0;
        end else begin
            for (int i = 0; i < TRACK_N; i++)
                if (kill[i]) tbl[i].valid <= 1'b0;
            if (wr_en) begin
                tbl[widx] <= '{valid: 1'b1, areg: wr_reg, spill: wr_spill};
                if (!hit) rr <= rr == RW'(TRACK_N - 1) ? '0 : rr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ras_unit.sv
// ras_unit: circular return-address stack with multi-stage rollback.
// Define RAS_TRACK_EN to include the ra-alias tracking table.
module ras_unit
    import ras_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int RB_STAGES = 2,
    parameter int TRACK_N   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [XLEN-1:0]      push_addr,
    input  logic                 pop,
    output logic [XLEN-1:0]      top_addr,
    output logic                 top_valid,
    input  logic [RB_STAGES-1:0] rb_undo_push,
    input  logic [RB_STAGES-1:0] rb_undo_pop,
    input  logic                 track_wr_en,
    input  logic [4:0]           track_wr_reg,
    input  logic                 track_wr_spill,
    input  logic                 rd_wr_en,
    input  logic [4:0]           rd_wr_reg,
    input  logic [4:0]           query_reg,
    input  logic                 query_load_dep,
    output logic                 ra_hit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]    mem [DEPTH];
    logic [PW-1:0]      ptr, ptr_m1, ptr_next, widx;
    logic [CW-1:0]      count, count_next;
    logic               rollback, wr_en;
    logic signed [15:0] delta, cnt_rb;

    assign rollback  = |rb_undo_push || |rb_undo_pop;
    assign ptr_m1    = ptr - 1'b1;
    assign top_addr  = mem[ptr_m1];
    assign top_valid = count != '0;
    assign wr_en     = push && !rollback;
    assign widx      = pop ? ptr_m1 : ptr;

    always_comb begin
        delta = '0;
        for (int i = 0; i < RB_STAGES; i++)
            delta = delta + 16'(rb_undo_pop[i]) - 16'(rb_undo_push[i]);
        cnt_rb     = $signed(16'(count)) + delta;
        ptr_next   = ptr;
        count_next = count;
        if (rollback) begin
            ptr_next   = ptr + PW'(delta);
            count_next = cnt_rb < 0 ? '0 : cnt_rb > DEPTH ? CW'(DEPTH) : CW'(cnt_rb);
        end else if (push && !pop) begin
            ptr_next   = ptr + 1'b1;
            count_next = count == CW'(DEPTH) ? count : count + 1'b1;
        end else if (pop && !push && count != '0) begin
            ptr_next   = ptr_m1;
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            ptr   <= ptr_next;
            count <= count_next;
            if (wr_en) mem[widx] <= push_addr;
        end
    end

`ifdef RAS_TRACK_EN
    ras_track_table #(.TRACK_N(TRACK_N)) u_track (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (pop || rollback),
        .wr_en         (track_wr_en),
        .wr_reg        (track_wr_reg),
        .wr_spill      (track_wr_spill),
        .rd_wr_en      (rd_wr_en),
        .rd_wr_reg     (rd_wr_reg),
        .query_reg     (query_reg),
        .query_load_dep(query_load_dep),
        .ra_hit        (ra_hit)
    );
`else
    logic unused_track;
    assign unused_track = ^{track_wr_en, track_wr_reg, track_wr_spill, rd_wr_en, rd_wr_reg, query_load_dep};
    assign ra_hit = query_reg == REG_RA;
`endif
endmodule

// File: tb/tb_ras_unit.sv
// tb_ras_unit: directed vector table for the stack plus hand sequences for alias tracking and reset.
module tb_ras_unit;
    import ras_pkg::*;

`ifdef RAS_TRACK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, push, pop, top_valid, ra_hit;
    logic [31:0] push_addr, top_addr;
    logic [1:0]  rb_undo_push, rb_undo_pop;
    logic        track_wr_en, track_wr_spill, rd_wr_en, query_load_dep;
    logic [4:0]  track_wr_reg, rd_wr_reg, query_reg;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    ras_unit #(.XLEN(32), .DEPTH(8), .RB_STAGES(2), .TRACK_N(2)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_addr(push_addr), .pop(pop),
        .top_addr(top_addr), .top_valid(top_valid),
        .rb_undo_push(rb_undo_push), .rb_undo_pop(rb_undo_pop),
        .track_wr_en(track_wr_en), .track_wr_reg(track_wr_reg), .track_wr_spill(track_wr_spill),
        .rd_wr_en(rd_wr_en), .rd_wr_reg(rd_wr_reg),
        .query_reg(query_reg), .query_load_dep(query_load_dep), .ra_hit(ra_hit)
    );

    typedef struct {
        logic        push;
        logic [31:0] addr;
        logic        pop;
        logic [1:0]  upush;
        logic [1:0]  upop;
        logic [31:0] top;
        logic        valid;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic pu, logic [31:0] a, logic po, logic [1:0] up, logic [1:0] uo,
                                logic [31:0] t, logic v);
        vec_t r;
        r.push = pu; r.addr = a; r.pop = po; r.upush = up; r.upop = uo; r.top = t; r.valid = v;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(string name, logic [4:0] r, logic dep, logic exp);
        query_reg = r;
        query_load_dep = dep;
        #1;
        chk(name, 32'(ra_hit), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; push = 0; pop = 0; push_addr = '0; rb_undo_push = '0; rb_undo_pop = '0;
        track_wr_en = 0; track_wr_reg = '0; track_wr_spill = 0; rd_wr_en = 0; rd_wr_reg = '0;
        query_reg = '0; query_load_dep = 0;
        tick(); tick();
        chk("reset_top", top_addr, 32'h0);
        chk("reset_valid", 32'(top_valid), 32'h0);
        query("reset_ra", REG_RA, 1'b0, 1'b1);
        rst_n = 1'b1;

        vt.push_back(mk(1, 32'h100, 0, 2'b00, 2'b00, 32'h100, 1));
        vt.push_back(mk(1, 32'h200, 0, 2'b00, 2'b00, 32'h200, 1));
        vt.push_back(mk(0, 32'h0,   1, 2'b00, 2'b00, 32'h100, 1));
        vt.push_back(mk(0, 32'h0,   1, 2'b00, 2'b00, 32'h0,   0));
        vt.push_back(mk(0, 32'h0,   1, 2'b00, 2'b00, 32'h0,   0));
        for (int i = 1; i <= 9; i++)
            vt.push_back(mk(1, 32'(i * 16), 0, 2'b00, 2'b00, 32'(i * 16), 1));
        for (int i = 8; i >= 2; i--)
            vt.push_back(mk(0, 32'h0, 1, 2'b00, 2'b00, 32'(i * 16), 1));
        vt.push_back(mk(0, 32'h0,   1, 2'b00, 2'b00, 32'h90,  0));
        vt.push_back(mk(1, 32'h40,  0, 2'b00, 2'b00, 32'h40,  1));
        vt.push_back(mk(1, 32'h44,  1, 2'b00, 2'b00, 32'h44,  1));
        vt.push_back(mk(0, 32'h0,   1, 2'b00, 2'b00, 32'h90,  0));
        vt.push_back(mk(1, 32'hA0,  0, 2'b00, 2'b00, 32'hA0,  1));
        vt.push_back(mk(0, 32'h0,   1, 2'b00, 2'b00, 32'h90,  0));
        vt.push_back(mk(1, 32'hBB,  0, 2'b00, 2'b01, 32'hA0,  1));
        vt.push_back(mk(0, 32'h0,   0, 2'b11, 2'b00, 32'h80,  0));
        vt.push_back(mk(0, 32'h0,   0, 2'b00, 2'b11, 32'hA0,  1));
        vt.push_back(mk(0, 32'h0,   1, 2'b01, 2'b10, 32'hA0,  1));
        vt.push_back(mk(0, 32'h0,   0, 2'b00, 2'b00, 32'hA0,  1));

        foreach (vt[i]) begin
            push = vt[i].push; push_addr = vt[i].addr; pop = vt[i].pop;
            rb_undo_push = vt[i].upush; rb_undo_pop = vt[i].upop;
            tick();
            chk($sformatf("vec%0d_top", i), top_addr, vt[i].top);
            chk($sformatf("vec%0d_valid", i), 32'(top_valid), 32'(vt[i].valid));
        end
        push = 0; pop = 0; rb_undo_push = '0; rb_undo_pop = '0;

        query("a5_untracked", 5'd15, 1'b0, 1'b0);
        track_wr_en = 1; track_wr_reg = 5'd15; tick(); track_wr_en = 0;
        query("a5_tracked", 5'd15, 1'b0, TRK);
        rd_wr_en = 1; rd_wr_reg = 5'd15; tick(); rd_wr_en = 0;
        query("a5_overwritten", 5'd15, 1'b0, 1'b0);
        track_wr_en = 1; rd_wr_en = 1; tick(); track_wr_en = 0; rd_wr_en = 0;
        query("track_beats_rd", 5'd15, 1'b0, TRK);
        track_wr_en = 1; track_wr_spill = 1; track_wr_reg = REG_SP; tick();
        track_wr_en = 0; track_wr_spill = 0;
        query("spill_load", 5'd5, 1'b1, TRK);
        query("spill_noload", 5'd5, 1'b0, 1'b0);
        track_wr_en = 1; track_wr_reg = 5'd10; tick(); track_wr_en = 0;
        query("rr_evicted", 5'd15, 1'b0, 1'b0);
        query("rr_new", 5'd10, 1'b0, TRK);
        query("rr_spill_kept", 5'd5, 1'b1, TRK);
        pop = 1; tick(); pop = 0;
        query("pop_clears", 5'd10, 1'b0, 1'b0);
        track_wr_en = 1; track_wr_reg = 5'd12; tick(); track_wr_en = 0;
        query("retrack", 5'd12, 1'b0, TRK);
        rb_undo_push = 2'b01; tick(); rb_undo_push = '0;
        query("rollback_clears", 5'd12, 1'b0, 1'b0);

        push = 1; push_addr = 32'h55; tick(); push = 0;
        chk("pre_reset_top", top_addr, 32'h55);
        rst_n = 0; push = 1; rb_undo_pop = 2'b11; tick();
        push = 0; rb_undo_pop = '0; rst_n = 1;
        chk("mid_reset_top", top_addr, 32'h0);
        chk("mid_reset_valid", 32'(top_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
